// File: rtl/uart_tx_if.sv
// uart_tx_if: request/completion bundle between the formatter and the UART TX.
// master drives tx_start/din; slave returns tx_busy/tx_done_tick.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output tx_start, din,
    input  tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_start, din,
    output tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter, LSB first, driven by a 16x s_tick.
// Ports: clk, reset (async, low), s_tick, tx (registered line), bus (slave).
module uart_tx_core #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic s_tick,
  output logic tx,
  uart_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Tick counter must reach SB_TICK-1 for long stop bits.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [SW-1:0] BIT_END  = SW'(15);
  localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DBIT - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [2:0]      n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          b_d     = bus.din;
          s_cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_END) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_END) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_END) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx changes on the
    // same edge as the state, straight from a flop.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase

    // Busy stays up through the done cycle.
    busy_d = (state_d != IDLE) || done_d;
  end

  assign tx               = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: scoreboard bench for uart_tx_core.
// Line monitor decodes frames; tasks pop expected/received and compare.
module tb_uart_tx_core;

  localparam int TDIV = 4;

  typedef struct {
    logic [7:0] data;
    int         ticks;
    int         clks;
    int         gap;
    bit         start_ok;
    bit         stop_ok;
    bit         stable;
    bit         busy_done;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       tx_a, tx_b;
  logic       start_drv = 1'b0;
  logic [7:0] din_drv = 8'h00;
  logic       sel32 = 1'b0;

  int vec = 0;
  int miss = 0;

  uart_tx_if #(.DBIT(8)) ifa ();
  uart_tx_if #(.DBIT(8)) ifb ();

  assign ifa.tx_start = start_drv & ~sel32;
  assign ifa.din      = din_drv;
  assign ifb.tx_start = start_drv & sel32;
  assign ifb.din      = din_drv;

  uart_tx_core #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx(tx_a), .bus(ifa)
  );

  uart_tx_core #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .tx(tx_b), .bus(ifb)
  );

  always #5 clk = ~clk;

  int unsigned div_q = 0;
  always @(negedge clk) begin
    if (div_q == TDIV - 1) begin
      div_q  = 0;
      s_tick = 1'b1;
    end else begin
      div_q  = div_q + 1;
      s_tick = 1'b0;
    end
  end

  logic [7:0] expq[$];
  rec_t       rxq[$];
  int         cyc = 0;
  int         last_done = -100000;
  int         spurious = 0;
  bit         mon_act = 1'b0;
  logic       prev_ln = 1'b1;
  int         m_ticks = 0;
  int         m_clks = 0;
  int         idx;
  rec_t       cur;
  logic       ln, bz, dn;

  always @(posedge clk) begin
    #1;
    cyc++;
    ln = sel32 ? tx_b : tx_a;
    bz = sel32 ? ifb.tx_busy : ifa.tx_busy;
    dn = sel32 ? ifb.tx_done_tick : ifa.tx_done_tick;
    if (!reset) begin
      mon_act = 1'b0;
    end else if (mon_act) begin
      m_clks++;
      if (s_tick) m_ticks++;
      if (ln !== prev_ln && !(s_tick && m_ticks % 16 == 0))
        cur.stable = 1'b0;
      if (s_tick && m_ticks % 16 == 8) begin
        idx = m_ticks / 16;
        if (idx == 0) cur.start_ok = (ln === 1'b0);
        else if (idx <= 8) cur.data[idx-1] = ln;
        else if (ln !== 1'b1) cur.stop_ok = 1'b0;
      end
      if (dn === 1'b1) begin
        cur.ticks     = m_ticks;
        cur.clks      = m_clks;
        cur.busy_done = (bz === 1'b1);
        rxq.push_back(cur);
        mon_act   = 1'b0;
        last_done = cyc;
      end
    end else begin
      if (dn === 1'b1) spurious++;
      if (prev_ln === 1'b1 && ln === 1'b0) begin
        mon_act      = 1'b1;
        m_ticks      = 0;
        m_clks       = 0;
        cur.data     = 8'h00;
        cur.start_ok = 1'b0;
        cur.stop_ok  = 1'b1;
        cur.stable   = 1'b1;
        cur.gap      = cyc - last_done;
      end
    end
    prev_ln = reset ? ln : 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input bit align);
    @(negedge clk);
    #1;
    if (align) begin
      for (int i = 0; i < TDIV && !s_tick; i++) begin
        @(negedge clk);
        #1;
      end
    end
    din_drv   = b;
    start_drv = 1'b1;
    expq.push_back(b);
    @(negedge clk);
    #1;
    start_drv = 1'b0;
    din_drv   = 8'($urandom);
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (rxq.size() < n && c < budget) begin
      step();
      c++;
    end
    ok = (rxq.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      din_drv   = 8'($urandom);
      start_drv = 1'($urandom);
      step();
      vec++;
      if ({tx_a, ifa.tx_busy, ifa.tx_done_tick,
           tx_b, ifb.tx_busy, ifb.tx_done_tick} !== 6'b100100) begin
        miss++;
        $display("FAIL reset_hold got %b exp 100100",
          {tx_a, ifa.tx_busy, ifa.tx_done_tick,
           tx_b, ifb.tx_busy, ifb.tx_done_tick});
      end
    end
    start_drv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    vec++;
    if ({tx_a, ifa.tx_busy, tx_b, ifb.tx_busy} !== 4'b1010) begin
      miss++;
      $display("FAIL reset_release got %b exp 1010",
        {tx_a, ifa.tx_busy, tx_b, ifb.tx_busy});
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    rec_t r;
    logic [7:0] e;
    send(8'h41, 1'b1);
    vec++;
    if ({tx_a, ifa.tx_busy} !== 2'b01) begin
      miss++;
      $display("FAIL start_edge got %b exp 01", {tx_a, ifa.tx_busy});
    end
    wait_rx(1, 1000, ok);
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL single_timeout got 0 frames exp 1");
    end else begin
      vec++;
      if ({ifa.tx_done_tick, ifa.tx_busy} !== 2'b11) begin
        miss++;
        $display("FAIL done_cycle got %b exp 11",
          {ifa.tx_done_tick, ifa.tx_busy});
      end
      r = rxq.pop_front();
      e = expq.pop_front();
      vec++;
      if ({r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done}
          !== {e, 4'b1111}) begin
        miss++;
        $display("FAIL single_frame got %h/%b%b%b%b exp %h/1111",
          r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done, e);
      end
      vec++;
      if (r.ticks != 160 || r.clks != 640) begin
        miss++;
        $display("FAIL single_timing got %0d ticks %0d clks exp 160 640",
          r.ticks, r.clks);
      end
      step();
      vec++;
      if ({tx_a, ifa.tx_busy, ifa.tx_done_tick} !== 3'b100) begin
        miss++;
        $display("FAIL after_done got %b exp 100",
          {tx_a, ifa.tx_busy, ifa.tx_done_tick});
      end
    end
    repeat (40) step();
    vec++;
    if (rxq.size() != 0 || mon_act || spurious != 0) begin
      miss++;
      $display("FAIL single_extra got %0d frames %0d stray exp 0 0",
        rxq.size() + int'(mon_act), spurious);
    end
  endtask

  task automatic test_held_start();
    logic [7:0] bytes [3];
    rec_t r;
    logic [7:0] e;
    int n;
    bytes[0] = 8'h31;
    bytes[1] = 8'h32;
    bytes[2] = 8'h33;
    @(negedge clk);
    #1;
    din_drv   = bytes[0];
    start_drv = 1'b1;
    expq.push_back(bytes[0]);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (ifa.tx_done_tick !== 1'b1 && n < 2000);
      vec++;
      if (ifa.tx_done_tick !== 1'b1) begin
        miss++;
        $display("FAIL held_timeout frame %0d got no done exp done", k);
      end
      if (k < 2) begin
        din_drv = bytes[k+1];
        expq.push_back(bytes[k+1]);
      end else begin
        start_drv = 1'b0;
      end
    end
    repeat (800) step();
    vec++;
    if (rxq.size() != 3 || mon_act) begin
      miss++;
      $display("FAIL held_count got %0d frames active %0d exp 3 0",
        rxq.size(), mon_act);
    end
    for (int k = 0; k < 3 && rxq.size() > 0 && expq.size() > 0; k++) begin
      r = rxq.pop_front();
      e = expq.pop_front();
      vec++;
      if ({r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done}
          !== {e, 4'b1111} || r.ticks != 160) begin
        miss++;
        $display("FAIL held_frame%0d got %h/%b%b%b%b/%0d exp %h/1111/160",
          k, r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done,
          r.ticks, e);
      end
      if (k > 0) begin
        vec++;
        if (r.gap != 1) begin
          miss++;
          $display("FAIL held_gap%0d got %0d exp 1", k, r.gap);
        end
      end
    end
    rxq.delete();
    expq.delete();
  endtask

  task automatic test_busy_immunity();
    bit ok;
    rec_t r;
    logic [7:0] e;
    send(8'h00, 1'b0);
    repeat (320) step();
    @(negedge clk);
    #1;
    din_drv   = 8'hFF;
    start_drv = 1'b1;
    @(negedge clk);
    #1;
    start_drv = 1'b0;
    wait_rx(1, 1000, ok);
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL busy_timeout got 0 frames exp 1");
    end else begin
      r = rxq.pop_front();
      e = expq.pop_front();
      vec++;
      if ({r.data, r.start_ok, r.stop_ok, r.stable}
          !== {e, 3'b111} || r.ticks != 160) begin
        miss++;
        $display("FAIL busy_frame got %h/%b%b%b/%0d exp %h/111/160",
          r.data, r.start_ok, r.stop_ok, r.stable, r.ticks, e);
      end
    end
    repeat (400) step();
    vec++;
    if (rxq.size() != 0 || mon_act || tx_a !== 1'b1 || ifa.tx_busy !== 1'b0) begin
      miss++;
      $display("FAIL busy_second got %0d frames tx %b exp 0 frames tx 1",
        rxq.size() + int'(mon_act), tx_a);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rec_t r;
    logic [7:0] e;
    int n;
    send(8'h55, 1'b1);
    n = 0;
    while (!(mon_act && m_ticks >= 68) && n < 1000) begin
      step();
      n++;
    end
    vec++;
    if (!(mon_act && m_ticks >= 68) || tx_a !== 1'b0) begin
      miss++;
      $display("FAIL mid_reach got tx %b ticks %0d exp tx 0 ticks 68",
        tx_a, m_ticks);
    end
    reset = 1'b0;
    #1;
    vec++;
    if ({tx_a, ifa.tx_busy} !== 2'b10) begin
      miss++;
      $display("FAIL mid_async got %b exp 10", {tx_a, ifa.tx_busy});
    end
    void'(expq.pop_front());
    repeat (5) step();
    @(negedge clk);
    reset = 1'b1;
    repeat (300) step();
    vec++;
    if (rxq.size() != 0 || spurious != 0 || tx_a !== 1'b1) begin
      miss++;
      $display("FAIL mid_nodone got %0d frames %0d stray exp 0 0",
        rxq.size(), spurious);
    end
    send(8'hAA, 1'b1);
    wait_rx(1, 1000, ok);
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL mid_timeout got 0 frames exp 1");
    end else begin
      r = rxq.pop_front();
      e = expq.pop_front();
      vec++;
      if ({r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done}
          !== {e, 4'b1111} || r.clks != 640) begin
        miss++;
        $display("FAIL mid_frame got %h/%b%b%b%b/%0d exp %h/1111/640",
          r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done,
          r.clks, e);
      end
    end
  endtask

  task automatic test_stop_param();
    bit ok;
    rec_t r;
    logic [7:0] e;
    repeat (5) step();
    sel32 = 1'b1;
    send(8'h0D, 1'b1);
    vec++;
    if ({tx_b, ifb.tx_busy, tx_a} !== 3'b011) begin
      miss++;
      $display("FAIL sb32_start got %b exp 011", {tx_b, ifb.tx_busy, tx_a});
    end
    wait_rx(1, 1200, ok);
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL sb32_timeout got 0 frames exp 1");
    end else begin
      r = rxq.pop_front();
      e = expq.pop_front();
      vec++;
      if ({r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done}
          !== {e, 4'b1111}) begin
        miss++;
        $display("FAIL sb32_frame got %h/%b%b%b%b exp %h/1111",
          r.data, r.start_ok, r.stop_ok, r.stable, r.busy_done, e);
      end
      vec++;
      if (r.ticks != 176 || r.clks != 704) begin
        miss++;
        $display("FAIL sb32_timing got %0d ticks %0d clks exp 176 704",
          r.ticks, r.clks);
      end
      step();
      vec++;
      if ({tx_b, ifb.tx_busy, ifb.tx_done_tick} !== 3'b100) begin
        miss++;
        $display("FAIL sb32_after got %b exp 100",
          {tx_b, ifb.tx_busy, ifb.tx_done_tick});
      end
    end
    sel32 = 1'b0;
    vec++;
    if (spurious != 0) begin
      miss++;
      $display("FAIL stray_done got %0d exp 0", spurious);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_held_start();
    test_busy_immunity();
    test_reset_mid();
    test_stop_param();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
